simmem_delay_releaser: RTL

SIMMEM_DELAY_RELEASER -- requirements
Module: simmem_delay_releaser

---
 rtl/simmem_delay_releaser.sv | 104 ++++++++++
 1 files changed

// File: rtl/simmem_delay_releaser.sv
// rtl/simmem_delay_releaser.sv - per-ID delay FIFOs gating response release in the simulated memory
module simmem_delay_releaser #(
  parameter int IDWidth    = 4,
  parameter int DelayWidth = 8,
  parameter int SlotsPerId = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [IDWidth-1:0]      in_id_i,
  input  logic [DelayWidth-1:0]   in_delay_i,
  output logic [2**IDWidth-1:0]   release_en_o,
  input  logic                    released_valid_i,
  input  logic [IDWidth-1:0]      released_id_i,
  output logic                    release_err_o
);

  localparam int NumIds = 2**IDWidth;
  localparam int PtrW   = $clog2(SlotsPerId);
  localparam int OccW   = PtrW + 1;

  logic [DelayWidth-1:0] cnt_q  [NumIds][SlotsPerId];
  logic [DelayWidth-1:0] cnt_d  [NumIds][SlotsPerId];
  logic [PtrW-1:0]       rptr_q [NumIds];
  logic [PtrW-1:0]       rptr_d [NumIds];
  logic [PtrW-1:0]       wptr_q [NumIds];
  logic [PtrW-1:0]       wptr_d [NumIds];
  logic [OccW-1:0]       occ_q  [NumIds];
  logic [OccW-1:0]       occ_d  [NumIds];
  logic                  err_q, err_d;

  logic accept, rel_ok;

  // Release permission reflects only the head entry of each ID, from registered state.
  always_comb begin
    release_en_o = '0;
    for (int i = 0; i < NumIds; i++) begin
      release_en_o[i] = (occ_q[i] != '0) && (cnt_q[i][rptr_q[i]] == '0);
    end
  end

  // Ready is purely a function of the current occupancy, so a same-cycle release never frees a slot early.
  assign in_ready_o    = occ_q[in_id_i] < OccW'(SlotsPerId);
  assign accept        = in_valid_i && in_ready_o;
  assign rel_ok        = released_valid_i && release_en_o[released_id_i];
  assign release_err_o = err_q;

  // Next state: count down occupied slots, load accepted entry, pop released head.
  always_comb begin
    err_d = released_valid_i && !release_en_o[released_id_i];
    for (int i = 0; i < NumIds; i++) begin
      rptr_d[i] = rptr_q[i];
      wptr_d[i] = wptr_q[i];
      occ_d[i]  = occ_q[i];
      for (int s = 0; s < SlotsPerId; s++) begin
        // A slot is occupied when its distance from the read pointer is below the occupancy.
        if (({1'b0, PtrW'(PtrW'(s) - rptr_q[i])} < occ_q[i]) && (cnt_q[i][s] != '0)) begin
          cnt_d[i][s] = cnt_q[i][s] - DelayWidth'(1);
        end else begin
          cnt_d[i][s] = cnt_q[i][s];
        end
      end
      if (accept && (in_id_i == IDWidth'(i))) begin
        cnt_d[i][wptr_q[i]] = in_delay_i;
        wptr_d[i]           = wptr_q[i] + PtrW'(1);
      end
      if (rel_ok && (released_id_i == IDWidth'(i))) begin
        rptr_d[i] = rptr_q[i] + PtrW'(1);
      end
      case ({accept && (in_id_i == IDWidth'(i)), rel_ok && (released_id_i == IDWidth'(i))})
        2'b10:   occ_d[i] = occ_q[i] + OccW'(1);
        2'b01:   occ_d[i] = occ_q[i] - OccW'(1);
        default: occ_d[i] = occ_q[i];
      endcase
    end
  end

  // State registers with asynchronous clear that discards all pending entries.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
      for (int i = 0; i < NumIds; i++) begin
        rptr_q[i] <= '0;
        wptr_q[i] <= '0;
        occ_q[i]  <= '0;
        for (int s = 0; s < SlotsPerId; s++) begin
          cnt_q[i][s] <= '0;
        end
      end
    end else begin
      err_q <= err_d;
      for (int i = 0; i < NumIds; i++) begin
        rptr_q[i] <= rptr_d[i];
        wptr_q[i] <= wptr_d[i];
        occ_q[i]  <= occ_d[i];
        for (int s = 0; s < SlotsPerId; s++) begin
          cnt_q[i][s] <= cnt_d[i][s];
        end
      end
    end
  end

endmodule
